// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: one full-adder slice computes a + ~b + ~borrow per clock, LSB first.
// A start/busy/done handshake frames each WIDTH-cycle operation; results update only at completion.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int SR_W  = WIDTH - 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_q, b_q;
    logic [CNT_W-1:0] cnt_q;
    logic             brw_q;
    logic [SR_W-1:0]  sr_q;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_out_q, overflow_q;

    logic             accept, last_bit;
    logic [1:0]       slice;

    // Returns {borrow_next, sum_bit} for a - b - borrow via a + ~b + ~borrow.
    function automatic logic [1:0] sub_slice(input logic a_bit, input logic b_bit,
                                             input logic borrow);
        logic nb, cin, s, cout;
        nb   = ~b_bit;
        cin  = ~borrow;
        s    = a_bit ^ nb ^ cin;
        cout = (a_bit & nb) | (a_bit & cin) | (nb & cin);
        return {~cout, s};
    endfunction

    assign accept   = start && ((state == IDLE) || (state == DONE));
    assign last_bit = (cnt_q == LAST);
    assign slice    = sub_slice(a_q[cnt_q], b_q[cnt_q], brw_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SHIFT;
            SHIFT:   if (last_bit) state_nxt = DONE;
            DONE:    state_nxt = accept ? SHIFT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Partial bits live in sr_q; the visible result registers change only on the last bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q          <= '0;
            b_q          <= '0;
            cnt_q        <= '0;
            brw_q        <= 1'b0;
            sr_q         <= '0;
            diff_q       <= '0;
            borrow_out_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else if (accept) begin
            a_q   <= a;
            b_q   <= b;
            brw_q <= borrow_in;
            cnt_q <= '0;
        end else if (state == SHIFT) begin
            sr_q  <= (sr_q >> 1) | (SR_W'(slice[0]) << (SR_W - 1));
            brw_q <= slice[1];
            if (last_bit) begin
                cnt_q        <= '0;
                diff_q       <= {slice[0], sr_q};
                borrow_out_q <= slice[1];
                overflow_q   <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (slice[0] != a_q[WIDTH-1]);
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign busy       = (state == SHIFT);
    assign done       = (state == DONE);
    assign diff       = diff_q;
    assign borrow_out = borrow_out_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: directed WIDTH=4 cases plus a randomized WIDTH=8 sweep,
// both checked every cycle against a timeline model built on plain integer arithmetic.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       st4 = 1'b0, bi4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       busy4, done4, bo4, ov4;
    logic [3:0] diff4;

    logic       st8 = 1'b0, bi8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, bo8, ov8;
    logic [7:0] diff8;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(st4), .a(a4), .b(b4), .borrow_in(bi4),
        .busy(busy4), .done(done4), .diff(diff4), .borrow_out(bo4), .overflow(ov4)
    );

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(st8), .a(a8), .b(b8), .borrow_in(bi8),
        .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bo8), .overflow(ov8)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference result {overflow, borrow_out, diff[7:0]} of a - b - bi at width w.
    function automatic logic [9:0] ref_sub(input int w, input logic [7:0] a, input logic [7:0] b,
                                           input logic bi);
        int r, sa, sb, sr;
        logic [9:0] res;
        r  = int'(a) - int'(b) - int'(bi);
        sa = a[w-1] ? int'(a) - (1 << w) : int'(a);
        sb = b[w-1] ? int'(b) - (1 << w) : int'(b);
        sr = sa - sb - int'(bi);
        res      = '0;
        res[7:0] = 8'((r + (1 << w)) & ((1 << w) - 1));
        res[8]   = (r < 0);
        res[9]   = (sr < -(1 << (w - 1))) || (sr > (1 << (w - 1)) - 1);
        return res;
    endfunction

    // Timeline model: an accepted start yields w busy cycles, then one done cycle
    // at which the pending result becomes the held output. left==1 marks the done cycle.
    int         left4 = 0, left8 = 0, ops8 = 0;
    logic [9:0] pend4 = '0, held4 = '0, pend8 = '0, held8 = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            left4 <= 0; pend4 <= '0; held4 <= '0;
        end else if (left4 <= 1 && st4) begin
            left4 <= 5;
            pend4 <= ref_sub(4, {4'b0, a4}, {4'b0, b4}, bi4);
        end else if (left4 > 0) begin
            left4 <= left4 - 1;
            if (left4 == 2) held4 <= pend4;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            left8 <= 0; pend8 <= '0; held8 <= '0;
        end else if (left8 <= 1 && st8) begin
            left8 <= 9;
            pend8 <= ref_sub(8, a8, b8, bi8);
        end else if (left8 > 0) begin
            left8 <= left8 - 1;
            if (left8 == 2) begin
                held8 <= pend8;
                ops8  <= ops8 + 1;
            end
        end
    end

    // Every-cycle comparison of both DUTs against the model.
    initial begin
        int run8;
        run8 = 0;
        forever begin
            @(negedge clk);
            check("busy4", busy4, left4 >= 2);
            check("done4", done4, left4 == 1);
            check("result4", {ov4, bo4, diff4}, {held4[9:8], held4[3:0]});
            check("busy8", busy8, left8 >= 2);
            check("done8", done8, left8 == 1);
            check("result8", {ov8, bo8, diff8}, held8);
            check("busy_done_excl", busy8 & done8, 0);
            if (busy8) run8++;
            else if (run8 != 0) begin
                check("busy8_len", run8, 8);
                run8 = 0;
            end
        end
    end

    task automatic start4(input logic [3:0] a, input logic [3:0] b, input logic bi);
        @(posedge clk); #2;
        st4 = 1'b1; a4 = a; b4 = b; bi4 = bi;
        @(posedge clk); #2;
        st4 = 1'b0;
    endtask

    // Called just after the accepting edge; the first negedge seen is cycle 1.
    task automatic wait_done4(output int cyc, output int bc);
        cyc = 0;
        bc  = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy4) bc++;
            if (done4) begin
                cyc = i + 1;
                break;
            end
        end
        if (cyc == 0) begin
            failures++;
            checks++;
            $display("FAIL done4_timeout: no done within 20 cycles");
        end
    endtask

    task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic bi,
                       input logic [3:0] ed, input logic ebo, input logic eov, input string nm);
        int cyc, bc;
        start4(a, b, bi);
        wait_done4(cyc, bc);
        check({nm, " diff"}, diff4, ed);
        check({nm, " borrow_out"}, bo4, ebo);
        check({nm, " overflow"}, ov4, eov);
        check({nm, " latency"}, cyc, 5);
        check({nm, " busy_cycles"}, bc, 4);
    endtask

    initial begin
        int cyc, bc;

        check("model 7-3", ref_sub(4, 8'd7, 8'd3, 1'b0), {2'b00, 8'h04});
        check("model 3-9", ref_sub(4, 8'd3, 8'd9, 1'b0), {2'b11, 8'h0A});
        check("model 8-1", ref_sub(4, 8'd8, 8'd1, 1'b0), {2'b10, 8'h07});
        check("model 5-5-1", ref_sub(4, 8'd5, 8'd5, 1'b1), {2'b01, 8'h0F});

        repeat (3) @(posedge clk);
        #2;
        check("reset diff", diff4, 0);
        check("reset busy", busy4, 0);
        check("reset done", done4, 0);
        check("reset flags", {ov4, bo4}, 0);
        rst_n = 1'b1;

        op4(4'd7, 4'd3, 1'b0, 4'h4, 1'b0, 1'b0, "7-3");
        op4(4'd3, 4'd9, 1'b0, 4'hA, 1'b1, 1'b1, "3-9");
        op4(4'd8, 4'd1, 1'b0, 4'h7, 1'b0, 1'b1, "8-1");
        op4(4'd5, 4'd5, 1'b1, 4'hF, 1'b1, 1'b0, "5-5-1");

        // start during SHIFT is ignored and operand changes must not leak in
        start4(4'd7, 4'd3, 1'b0);
        st4 = 1'b1; a4 = 4'hF; b4 = 4'h0; bi4 = 1'b1;
        @(posedge clk); #2;
        @(posedge clk); #2;
        st4 = 1'b0;
        wait_done4(cyc, bc);
        check("ignored diff", diff4, 4'h4);
        check("ignored latency", cyc, 3);
        st4 = 1'b1; a4 = 4'd2; b4 = 4'd1; bi4 = 1'b0;
        @(posedge clk); #2;
        st4 = 1'b0;
        wait_done4(cyc, bc);
        check("b2b diff", diff4, 4'h1);
        check("b2b latency", cyc, 5);

        // asynchronous reset mid-operation
        start4(4'd7, 4'd3, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst diff", diff4, 0);
        check("midrst busy", busy4, 0);
        check("midrst done", done4, 0);
        check("midrst flags", {ov4, bo4}, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("midrst no_done", done4, 0);
        end
        @(posedge clk); #2;
        rst_n = 1'b1;
        op4(4'd7, 4'd3, 1'b0, 4'h4, 1'b0, 1'b0, "post_rst 7-3");

        // WIDTH=8 random sweep with random start pressure and operand churn
        for (int c = 0; c < 15000; c++) begin
            @(posedge clk); #2;
            st8 = 1'($urandom_range(0, 1));
            a8  = 8'($urandom);
            b8  = 8'($urandom);
            bi8 = 1'($urandom_range(0, 1));
        end
        st8 = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        check("ops8 >= 1000", ops8 >= 1000, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
